// File: rtl/vip_pkg.sv
// Shared types and helpers for the VIP window generators.
// Border policy encoding, window element indexing and fixed pipeline latency.
package vip_pkg;

   typedef enum logic [1:0] {
      BORDER_ZERO = 2'd0,
      BORDER_REPL = 2'd1,
      BORDER_RAW  = 2'd2
   } border_e;

   localparam int LAT = 2;

   function automatic int win_idx(input int r, input int c, input int k);
      return r * k + c;
   endfunction

   // Reserved encoding 3 behaves as zero fill.
   function automatic border_e decode_border(input logic [1:0] m);
      case (m)
         2'd1:    return BORDER_REPL;
         2'd2:    return BORDER_RAW;
         default: return BORDER_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/vip_line_ram.sv
// One-line pixel store: single write port, registered read port (1-cycle read latency).
// No reset on the array; stale contents are masked downstream by the row count.
module vip_line_ram
   import vip_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int MAX_W  = 2048,
   localparam int AW     = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [MAX_W];
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rd_q <= mem_q[raddr_i];
   end

   assign rdata_o = rd_q;

endmodule

// File: rtl/vip_matrix_gen_kxk.sv
// Trailing KxK window generator over K-1 line buffers with runtime border policy.
// Fixed 2-cycle latency on data and syncs; no backpressure, one pixel per cycle while href.
module vip_matrix_gen_kxk
   import vip_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int K      = 3,
   parameter int MAX_W  = 2048,
   parameter int CNT_W  = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            border_mode,
   input  logic                  per_frame_vsync,
   input  logic                  per_frame_href,
   input  logic                  per_frame_hsync,
   input  logic [DATA_W-1:0]     per_img_data,
   output logic [K*K*DATA_W-1:0] matrix_data,
   output logic                  matrix_frame_vsync,
   output logic                  matrix_frame_href,
   output logic                  matrix_frame_hsync,
   output logic                  overflow
);

   // Column counter carries one extra bit so it can sit at MAX_W.
   localparam int CW = CNT_W + 1;
   localparam int RW = $clog2(K);
   localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   if (!(K == 3 || K == 5 || K == 7)) begin : g_bad_k
      $error("vip_matrix_gen_kxk: K must be 3, 5 or 7");
   end
   if ((2 ** CNT_W) < MAX_W) begin : g_bad_cnt
      $error("vip_matrix_gen_kxk: CNT_W too narrow for MAX_W");
   end

   logic              vsync_prev_q, href_prev_q;
   logic              vs_rise, href_fall;
   logic [CW-1:0]     col_q, col_d, col_eff;
   logic [RW-1:0]     row_q, row_d, row_eff;
   border_e           mode_q, mode_d;
   logic              ovf_q, ovf_d;
   logic [2:0]        sync_q [LAT];
   logic              href_s1;
   logic [DATA_W-1:0] pix_s1_q;
   logic [CW-1:0]     col_s1_q;
   logic [RW-1:0]     row_s1_q;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rd  [K-1];
   logic [DATA_W-1:0] col_vec [K];
   logic [DATA_W-1:0] win_q   [K][K];
   logic [RW-1:0]     rowv_q, colv_q;
   logic [RW-1:0]     first_row, first_col;

   assign vs_rise   = per_frame_vsync & ~vsync_prev_q;
   assign href_fall = href_prev_q & ~per_frame_href;

   // A vsync rise clears the counters in the same cycle it is seen.
   always_comb begin
      col_eff = vs_rise ? '0 : col_q;
      row_eff = vs_rise ? '0 : row_q;
      col_d   = '0;
      if (per_frame_href) col_d = (col_eff == CW'(MAX_W)) ? col_eff : col_eff + CW'(1);
      row_d = row_eff;
      if (href_fall && !vs_rise && row_q != RW'(K - 1)) row_d = row_q + RW'(1);
      mode_d = vs_rise ? decode_border(border_mode) : mode_q;
      ovf_d  = (vs_rise ? 1'b0 : ovf_q) | (per_frame_href && col_eff == CW'(MAX_W));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_prev_q <= 1'b0;
         href_prev_q  <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         mode_q       <= BORDER_ZERO;
         ovf_q        <= 1'b0;
         pix_s1_q     <= '0;
         col_s1_q     <= '0;
         row_s1_q     <= '0;
         for (int i = 0; i < LAT; i++) sync_q[i] <= '0;
      end else begin
         vsync_prev_q <= per_frame_vsync;
         href_prev_q  <= per_frame_href;
         col_q        <= col_d;
         row_q        <= row_d;
         mode_q       <= mode_d;
         ovf_q        <= ovf_d;
         pix_s1_q     <= per_img_data;
         col_s1_q     <= col_eff;
         row_s1_q     <= row_eff;
         sync_q[0]    <= {per_frame_vsync, per_frame_href, per_frame_hsync};
         for (int i = 1; i < LAT; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign href_s1 = sync_q[0][1];
   // Writes trail reads by one cycle so each RAM hands its old line to the next.
   assign ram_we  = href_s1 && (col_s1_q < CW'(MAX_W));

   for (genvar k = 0; k < K - 1; k++) begin : g_ram
      logic [DATA_W-1:0] wdata;
      if (k == 0) begin : g_first
         assign wdata = pix_s1_q;
      end else begin : g_chain
         assign wdata = ram_rd[k-1];
      end
      vip_line_ram #(.DATA_W(DATA_W), .MAX_W(MAX_W)) u_ram (
         .clk     (clk),
         .we_i    (ram_we),
         .waddr_i (col_s1_q[AW-1:0]),
         .wdata_i (wdata),
         .raddr_i (col_eff[AW-1:0]),
         .rdata_o (ram_rd[k])
      );
      assign col_vec[K-2-k] = ram_rd[k];
   end
   assign col_vec[K-1] = pix_s1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win_q[r][c] <= '0;
         rowv_q <= '0;
         colv_q <= '0;
      end else if (href_s1) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
            win_q[r][K-1] <= col_vec[r];
         end
         rowv_q <= row_s1_q;
         colv_q <= (col_s1_q > CW'(K - 1)) ? RW'(K - 1) : col_s1_q[RW-1:0];
      end
   end

   // Lowest valid window row/column for the pixel now at (K-1,K-1).
   assign first_row = RW'(K - 1) - rowv_q;
   assign first_col = RW'(K - 1) - colv_q;

   always_comb begin
      matrix_data = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            logic [RW-1:0]     sr, sc;
            logic [DATA_W-1:0] px;
            sr = RW'(r);
            sc = RW'(c);
            if (mode_q == BORDER_REPL) begin
               if (sr < first_row) sr = first_row;
               if (sc < first_col) sc = first_col;
            end
            px = win_q[sr][sc];
            if (mode_q == BORDER_ZERO && (RW'(r) < first_row || RW'(c) < first_col)) px = '0;
            matrix_data[win_idx(r, c, K)*DATA_W +: DATA_W] = px;
         end
      end
   end

   assign matrix_frame_vsync = sync_q[LAT-1][2];
   assign matrix_frame_href  = sync_q[LAT-1][1];
   assign matrix_frame_hsync = sync_q[LAT-1][0];
   assign overflow           = ovf_q;

endmodule

// File: tb/tb_vip_matrix_gen_kxk.sv
// Directed bench for the KxK window generator: K=3 and K=5 instances share one stimulus stream.
module tb_vip_matrix_gen_kxk;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   bm3, bm5;
   logic         vsync, href, hsync;
   logic [7:0]   pix;
   logic [71:0]  m3;
   logic [199:0] m5;
   logic         o_vs3, o_hr3, o_hs3, ovf3;
   logic         o_vs5, o_hr5, o_hs5, ovf5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vip_matrix_gen_kxk #(.DATA_W(8), .K(3), .MAX_W(16), .CNT_W(4)) u3 (
      .clk(clk), .rst_n(rst_n), .border_mode(bm3),
      .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_hsync(hsync), .per_img_data(pix),
      .matrix_data(m3), .matrix_frame_vsync(o_vs3), .matrix_frame_href(o_hr3),
      .matrix_frame_hsync(o_hs3), .overflow(ovf3));

   vip_matrix_gen_kxk #(.DATA_W(8), .K(5), .MAX_W(16), .CNT_W(4)) u5 (
      .clk(clk), .rst_n(rst_n), .border_mode(bm5),
      .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_hsync(hsync), .per_img_data(pix),
      .matrix_data(m5), .matrix_frame_vsync(o_vs5), .matrix_frame_href(o_hr5),
      .matrix_frame_hsync(o_hs5), .overflow(ovf5));

   typedef struct {
      int         dut;
      int         f;
      int         r;
      int         c;
      int         er;
      int         ec;
      logic [7:0] exp;
   } vec_t;

   vec_t vq[$];

   // Output windows captured per (dut, frame, row, col) as counted from the output syncs.
   logic [199:0] cap [2][3][4][8];
   int   frm = -1;
   int   orow = 0, ocol = 0;
   logic pvs = 1'b0, phr = 1'b0;

   always @(negedge clk) begin
      if (o_vs3 && !pvs) begin
         frm++;
         orow = 0;
         ocol = 0;
      end
      if (o_hr3) begin
         if (frm >= 0 && frm < 3 && orow < 4 && ocol < 8) begin
            cap[0][frm][orow][ocol] = 200'(m3);
            cap[1][frm][orow][ocol] = m5;
         end
         ocol++;
      end else if (phr) begin
         orow++;
         ocol = 0;
      end
      pvs = o_vs3;
      phr = o_hr3;
   end

   function automatic logic [7:0] el(input logic [199:0] m, input int k, input int r, input int c);
      return m[(r*k+c)*8 +: 8];
   endfunction

   task automatic chk(input string nm, input logic [199:0] got, input logic [199:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic add(input int dut, input int f, input int r, input int c,
                      input int er, input int ec, input logic [7:0] exp);
      vec_t v;
      v = '{dut, f, r, c, er, ec, exp};
      vq.push_back(v);
   endtask

   task automatic cyc(input logic vs, input logic hr, input logic hs, input logic [7:0] px);
      @(posedge clk);
      #1;
      vsync = vs;
      href  = hr;
      hsync = hs;
      pix   = px;
   endtask

   task automatic gap();
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Modes are scrambled right after vsync to show they only take effect at the rise.
   task automatic frame(input logic [1:0] md3, input logic [1:0] md5);
      bm3 = md3;
      bm5 = md5;
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      bm3 = ~md3;
      bm5 = ~md5;
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      for (int l = 0; l < 4; l++) begin
         for (int c = 0; c < 8; c++) cyc(1'b0, 1'b1, 1'b0, 8'(l * 16 + c));
         gap();
      end
   endtask

   logic [2:0]   pat [20];
   logic [199:0] prev3;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      vsync = 1'b0; href = 1'b0; hsync = 1'b0; pix = 8'h00;
      bm3 = 2'd0; bm5 = 2'd0;

      // K=3 mode 0, frame 0
      add(3,0,0,0,2,2,8'h00); add(3,0,0,0,0,0,8'h00);
      add(3,0,0,3,2,0,8'h01); add(3,0,0,3,2,2,8'h03); add(3,0,0,3,1,1,8'h00);
      add(3,0,1,0,2,2,8'h10); add(3,0,1,0,1,2,8'h00); add(3,0,1,0,2,1,8'h00);
      add(3,0,2,2,0,0,8'h00); add(3,0,2,2,2,2,8'h22); add(3,0,2,2,1,1,8'h11);
      add(3,0,3,7,0,0,8'h15); add(3,0,3,7,0,2,8'h17); add(3,0,3,7,2,0,8'h35); add(3,0,3,7,1,1,8'h26);
      // K=5 mode 1, frame 0
      add(5,0,0,0,0,0,8'h00); add(5,0,0,0,4,4,8'h00); add(5,0,0,0,2,3,8'h00);
      add(5,0,1,3,0,0,8'h00); add(5,0,1,3,0,4,8'h03); add(5,0,1,3,3,2,8'h01);
      add(5,0,1,3,4,4,8'h13); add(5,0,1,3,4,0,8'h10); add(5,0,1,3,2,3,8'h02);
      add(5,0,2,1,0,0,8'h00); add(5,0,2,1,4,0,8'h20); add(5,0,2,1,4,4,8'h21); add(5,0,2,1,3,4,8'h11);
      add(5,0,3,7,0,0,8'h03); add(5,0,3,7,0,4,8'h07); add(5,0,3,7,1,0,8'h03);
      add(5,0,3,7,4,4,8'h37); add(5,0,3,7,2,2,8'h15);
      // K=3 mode 2 (raw) frame 1: top rows still hold the previous frame
      add(3,1,0,2,0,0,8'h20); add(3,1,0,2,0,2,8'h22); add(3,1,0,2,1,0,8'h30);
      add(3,1,0,2,1,2,8'h32); add(3,1,0,2,2,0,8'h00); add(3,1,0,2,2,2,8'h02);
      // K=5 mode 0 frame 1
      add(5,1,0,0,3,4,8'h00); add(5,1,0,0,4,4,8'h00);
      add(5,1,1,4,4,4,8'h14); add(5,1,1,4,3,1,8'h01); add(5,1,1,4,2,4,8'h00);
      // frame 2: K=3 reserved mode acts as zero fill, K=5 replicate
      add(3,2,0,2,0,0,8'h00); add(3,2,0,2,1,1,8'h00); add(3,2,0,2,2,2,8'h02);
      add(5,2,0,2,0,0,8'h00); add(5,2,0,2,1,4,8'h02); add(5,2,0,2,3,3,8'h01);

      pat = '{3'b000, 3'b010, 3'b010, 3'b000, 3'b010, 3'b001, 3'b010, 3'b000, 3'b100, 3'b100,
              3'b010, 3'b011, 3'b000, 3'b010, 3'b110, 3'b000, 3'b010, 3'b010, 3'b001, 3'b000};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m3", 200'(m3), '0);
      chk("rst_m5", m5, '0);
      chk("rst_syncs", 200'({o_vs3, o_hr3, o_hs3, o_vs5, o_hr5, o_hs5}), '0);
      chk("rst_ovf", 200'({ovf3, ovf5}), '0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      frame(2'd0, 2'd1);
      frame(2'd2, 2'd0);
      frame(2'd3, 2'd1);
      repeat (4) cyc(1'b0, 1'b0, 1'b0, 8'h00);

      foreach (vq[i]) begin
         int d;
         d = (vq[i].dut == 3) ? 0 : 1;
         chk($sformatf("win K%0d f%0d r%0d c%0d e(%0d,%0d)", vq[i].dut, vq[i].f, vq[i].r, vq[i].c,
                       vq[i].er, vq[i].ec),
             200'(el(cap[d][vq[i].f][vq[i].r][vq[i].c], vq[i].dut, vq[i].er, vq[i].ec)),
             200'(vq[i].exp));
      end

      // Over-long line: MAX_W + 3 pixels.
      bm3 = 2'd0; bm5 = 2'd0;
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 19; c++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'(c));
         @(negedge clk);
         if (c == 16) chk("ovf_before_excess", 200'({ovf3, ovf5}), 200'(2'b00));
         if (c == 17) chk("ovf_first_excess", 200'({ovf3, ovf5}), 200'(2'b11));
      end
      gap();
      for (int c = 0; c < 8; c++) cyc(1'b0, 1'b1, 1'b0, 8'(16 + c));
      gap();
      @(negedge clk);
      chk("ovf_sticky", 200'({ovf3, ovf5}), 200'(2'b11));
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      chk("ovf_clear_vsync", 200'({ovf3, ovf5}), 200'(2'b00));
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'h00);

      // Reset in the middle of line 2.
      for (int l = 0; l < 2; l++) begin
         for (int c = 0; c < 8; c++) cyc(1'b0, 1'b1, 1'b0, 8'(l * 16 + c));
         gap();
      end
      for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 1'b0, 8'(32 + c));
      @(posedge clk);
      #1;
      rst_n = 1'b0; href = 1'b0; pix = 8'h00;
      @(negedge clk);
      chk("midrst_m3", 200'(m3), '0);
      chk("midrst_m5", m5, '0);
      chk("midrst_syncs", 200'({o_vs3, o_hr3, o_hs3, o_vs5, o_hr5, o_hs5}), '0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 8; c++) begin
         cyc(1'b0, 1'b1, 1'b0, 8'(8'hA0 + c));
         @(negedge clk);
         if (c == 4) begin
            chk("postrst K3 (2,2)", 200'(el(200'(m3), 3, 2, 2)), 200'(8'hA2));
            chk("postrst K3 (2,0)", 200'(el(200'(m3), 3, 2, 0)), 200'(8'hA0));
            chk("postrst K3 (1,1)", 200'(el(200'(m3), 3, 1, 1)), 200'(8'h00));
            chk("postrst K3 (0,2)", 200'(el(200'(m3), 3, 0, 2)), 200'(8'h00));
            chk("postrst K5 (4,4)", 200'(el(m5, 5, 4, 4)), 200'(8'hA2));
            chk("postrst K5 (4,2)", 200'(el(m5, 5, 4, 2)), 200'(8'hA0));
            chk("postrst K5 (3,4)", 200'(el(m5, 5, 3, 4)), 200'(8'h00));
         end
      end
      gap();

      // Sync alignment with 1-cycle gaps; window must hold while output href is low.
      @(negedge clk);
      prev3 = 200'(m3);
      for (int i = 0; i < 20; i++) begin
         cyc(pat[i][2], pat[i][1], pat[i][0], 8'(8'h50 + i));
         @(negedge clk);
         if (i >= 2) begin
            chk($sformatf("sync3 cyc%0d", i), 200'({o_vs3, o_hr3, o_hs3}), 200'(pat[i-2]));
            chk($sformatf("sync5 cyc%0d", i), 200'({o_vs5, o_hr5, o_hs5}), 200'(pat[i-2]));
         end
         if (!o_hr3) chk($sformatf("frozen cyc%0d", i), 200'(m3), prev3);
         prev3 = 200'(m3);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
